// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Definitions shared by the IO pad blocks (output serializer and the
// input-capture blocks).
//   io_oser_state_t    : serializer FSM states. PARITY exists only when
//                        IO_OSER_PARITY_EN is defined.
//   IO_IDLE_Z_DEFAULT  : default for a block's IDLE_Z parameter.
//   IO_IDLE_DRIVE_LVL  : level driven on a pad that is idle but not released.
//   io_even_parity()   : XOR of the bits of a word of up to 32 bits.
// Build macro: IO_OSER_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef IO_OSER_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } io_oser_state_t;

    localparam bit   IO_IDLE_Z_DEFAULT = 1'b1;
    localparam logic IO_IDLE_DRIVE_LVL = 1'b1;

    // Unused upper bits must be zero; they do not change the result.
    function automatic logic io_even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/io_oserializer_if.sv
// -----------------------------------------------------------------------------
// io_oserializer_if
// Valid/ready word handshake into the output serializer.
//   DATA  : parallel word to transmit (WIDTH bits)
//   VALID : DATA is valid
//   READY : serializer can accept a word; transfer on an edge with VALID && READY
// Modports: master (word source), slave (serializer).
// -----------------------------------------------------------------------------
interface io_oserializer_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] DATA;
    logic             VALID;
    logic             READY;

    modport master (
        output DATA,
        output VALID,
        input  READY
    );

    modport slave (
        input  DATA,
        input  VALID,
        output READY
    );

endinterface

// File: rtl/io_oserializer.sv
// -----------------------------------------------------------------------------
// io_oserializer
// Serializes parallel words onto a single pad, LSB first, one bit per IOCLK.
// A one-word holding register lets the next word be queued while a frame is
// being shifted, so consecutive frames leave the pad with no idle gap.
//
// Parameters
//   WIDTH  : data word width, 2..32
//   IDLE_Z : 1 = pad released (z) when idle, 0 = pad driven high when idle
// Ports
//   IOCLK  : clock, all state changes on its rising edge
//   RST    : synchronous active-high reset
//   bus    : io_oserializer_if.slave (DATA / VALID / READY)
//   PIN    : pad, serial output
//   BUSY   : a frame is being shifted onto PIN
//   DONE   : one-cycle pulse while the final bit of a frame is on PIN
// Build macro
//   IO_OSER_PARITY_EN : append an even-parity bit, frame becomes WIDTH+1 bits
// -----------------------------------------------------------------------------
module io_oserializer
    import io_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit IDLE_Z = IO_IDLE_Z_DEFAULT
) (
    input  logic               IOCLK,
    input  logic               RST,
    io_oserializer_if.slave    bus,
    inout  wire                PIN,
    output logic               BUSY,
    output logic               DONE
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    io_oser_state_t   state_q;
    io_oser_state_t   state_nx;

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic [CNT_W-1:0] cnt_q;

    logic             ready;
    logic             accept;
    logic             last_bit;
    logic             frame_end;
    logic             load_data;
    logic             load_hold;
    logic             hold_wr;
    logic [WIDTH-1:0] load_word;

    logic             pin_drive;
    logic             pin_val;

`ifdef IO_OSER_PARITY_EN
    logic             par_q;
    logic [31:0]      load_word_ext;
`endif

    assign accept    = bus.VALID && ready;
    assign last_bit  = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));
    assign load_word = load_hold ? hold_q : bus.DATA;

    // Word movement. A queued word always wins at frame end; a direct load
    // from DATA happens either from IDLE or as a same-edge bypass when
    // nothing is queued. Any other accept lands in the holding register.
    assign load_hold = frame_end && hold_full_q;
    assign load_data = accept && ((state_q == IDLE) || (frame_end && !hold_full_q));
    assign hold_wr   = accept && !load_data;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge IOCLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nx  = state_q;
        frame_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
`ifdef IO_OSER_PARITY_EN
                    state_nx = PARITY;
`else
                    frame_end = 1'b1;
                    state_nx  = (hold_full_q || accept) ? SHIFT : IDLE;
`endif
                end
            end
`ifdef IO_OSER_PARITY_EN
            PARITY: begin
                frame_end = 1'b1;
                state_nx  = (hold_full_q || accept) ? SHIFT : IDLE;
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: shift register, bit counter, holding register
    // ---------------------------------------------------------------------
    always_ff @(posedge IOCLK) begin
        if (RST) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
        end else begin
            if (load_hold || load_data) begin
                shift_q <= load_word;
                cnt_q   <= '0;
            end else if (state_q == SHIFT) begin
                shift_q <= shift_q >> 1;
                cnt_q   <= cnt_q + CNT_W'(1);
            end

            if (load_hold) begin
                hold_full_q <= 1'b0;
            end else if (hold_wr) begin
                hold_full_q <= 1'b1;
            end
        end
    end

    // Held data needs no reset: it is only ever read while hold_full_q is set.
    always_ff @(posedge IOCLK) begin
        if (hold_wr) begin
            hold_q <= bus.DATA;
        end
    end

`ifdef IO_OSER_PARITY_EN
    always_comb begin
        load_word_ext               = '0;
        load_word_ext[WIDTH-1:0]    = load_word;
    end

    // Parity is latched when a word enters the shifter, because the shifter
    // has emptied by the time the parity bit goes out.
    always_ff @(posedge IOCLK) begin
        if (load_hold || load_data) begin
            par_q <= io_even_parity(load_word_ext);
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        ready     = !hold_full_q && !RST;
        BUSY      = (state_q != IDLE);
        DONE      = frame_end;
        pin_drive = 1'b1;
        pin_val   = IO_IDLE_DRIVE_LVL;
        unique case (state_q)
            IDLE: begin
                pin_drive = !IDLE_Z;
                pin_val   = IO_IDLE_DRIVE_LVL;
            end
            SHIFT: begin
                pin_val = shift_q[0];
            end
`ifdef IO_OSER_PARITY_EN
            PARITY: begin
                pin_val = par_q;
            end
`endif
            default: begin
                pin_drive = !IDLE_Z;
                pin_val   = IO_IDLE_DRIVE_LVL;
            end
        endcase
    end

    assign bus.READY = ready;

    // Pad tristate
    assign PIN = pin_drive ? pin_val : 1'bz;

endmodule

// File: tb/tb_io_oserializer.sv
// -----------------------------------------------------------------------------
// tb_io_oserializer
// Directed bench for io_oserializer (WIDTH=8, IDLE_Z=1). The pad net has a
// pulldown, so a released pad reads 0 here while a driven idle-high reads 1.
// Expected bit streams below are hand-written constants: bit i of a stream
// is the value on PIN in the i-th cycle after the first accept.
// Build macro: IO_OSER_PARITY_EN selects the 9-bit-frame expectations.
// -----------------------------------------------------------------------------
module tb_io_oserializer;

    logic clk;
    logic rst;
    wire  pin;
    logic busy;
    logic done;

    int n_chk;
    int n_bad;

    io_oserializer_if #(.WIDTH(8)) bus ();

    pulldown pd0 (pin);

    io_oserializer #(
        .WIDTH (8),
        .IDLE_Z(1)
    ) dut (
        .IOCLK(clk),
        .RST  (rst),
        .bus  (bus),
        .PIN  (pin),
        .BUSY (busy),
        .DONE (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IO_OSER_PARITY_EN
    localparam int          FL      = 9;
    // A5 (parity 0)
    localparam logic [31:0] A5_BITS = 32'h0000_00A5;
    localparam logic [31:0] A5_DONE = 32'h0000_0100;
    // 0F (p0) then F0 (p0), second word queued
    localparam logic [31:0] BB_BITS = 32'h0001_E00F;
    localparam logic [31:0] BB_DONE = 32'h0002_0100;
    localparam logic [31:0] BB_RDY  = 32'h0003_FE01;
    // 3C (p0) then C3 (p0) via bypass
    localparam logic [31:0] BP_BITS = 32'h0001_863C;
    localparam logic [31:0] BP_DONE = 32'h0002_0100;
    localparam logic [31:0] BP_RDY  = 32'h0003_FFFF;
`else
    localparam int          FL      = 8;
    localparam logic [31:0] A5_BITS = 32'h0000_00A5;
    localparam logic [31:0] A5_DONE = 32'h0000_0080;
    localparam logic [31:0] BB_BITS = 32'h0000_F00F;
    localparam logic [31:0] BB_DONE = 32'h0000_8080;
    localparam logic [31:0] BB_RDY  = 32'h0000_FF01;
    localparam logic [31:0] BP_BITS = 32'h0000_C33C;
    localparam logic [31:0] BP_DONE = 32'h0000_8080;
    localparam logic [31:0] BP_RDY  = 32'h0000_FFFF;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pin"},   {31'b0, pin},       32'd0);
        chk({tag, "_busy"},  {31'b0, busy},      32'd0);
        chk({tag, "_done"},  {31'b0, done},      32'd0);
        chk({tag, "_ready"}, {31'b0, bus.READY}, 32'd1);
    endtask

    // Checks stream positions lo..hi-1, one per cycle, starting at a negedge
    // where position lo is on the pad; ends at the negedge after position hi-1.
    task automatic check_stream(input string tag, input logic [31:0] bits,
                                input logic [31:0] done_m, input logic [31:0] rdy_m,
                                input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            chk($sformatf("%s_pin%0d", tag, i),   {31'b0, pin},       {31'b0, bits[i]});
            chk($sformatf("%s_done%0d", tag, i),  {31'b0, done},      {31'b0, done_m[i]});
            chk($sformatf("%s_rdy%0d", tag, i),   {31'b0, bus.READY}, {31'b0, rdy_m[i]});
            chk($sformatf("%s_busy%0d", tag, i),  {31'b0, busy},      32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        bus.VALID = 1'b0;
        bus.DATA  = 8'h00;

        // Reset
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, bus.READY}, 32'd0);
        chk("rst_busy",  {31'b0, busy},      32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Idle for 10 cycles; DATA wiggles with VALID low and must be ignored
        for (int i = 0; i < 10; i++) begin
            chk_idle($sformatf("idle%0d", i));
            bus.DATA = 8'(8'h5A + i * 8'h11);
            @(negedge clk);
        end

        // Single word A5
        bus.DATA  = 8'hA5;
        bus.VALID = 1'b1;
        @(negedge clk);
        bus.VALID = 1'b0;
        bus.DATA  = 8'h00;
        check_stream("a5", A5_BITS, A5_DONE, 32'hFFFF_FFFF, 0, FL);
        chk_idle("a5_after");
        @(negedge clk);

        // Back-to-back 0F then F0, second word queued during the first frame
        bus.DATA  = 8'h0F;
        bus.VALID = 1'b1;
        @(negedge clk);
        bus.DATA  = 8'hF0;
        check_stream("bb", BB_BITS, BB_DONE, BB_RDY, 0, 1);
        bus.VALID = 1'b0;
        bus.DATA  = 8'h00;
        check_stream("bb", BB_BITS, BB_DONE, BB_RDY, 1, 2 * FL);
        chk_idle("bb_after");
        @(negedge clk);

        // Bypass: C3 offered on the frame-end edge of 3C with hold empty
        bus.DATA  = 8'h3C;
        bus.VALID = 1'b1;
        @(negedge clk);
        bus.VALID = 1'b0;
        bus.DATA  = 8'h00;
        check_stream("bp", BP_BITS, BP_DONE, BP_RDY, 0, FL - 1);
        bus.DATA  = 8'hC3;
        bus.VALID = 1'b1;
        check_stream("bp", BP_BITS, BP_DONE, BP_RDY, FL - 1, FL);
        bus.VALID = 1'b0;
        bus.DATA  = 8'h00;
        check_stream("bp", BP_BITS, BP_DONE, BP_RDY, FL, 2 * FL);
        chk_idle("bp_after");
        @(negedge clk);

`ifdef IO_OSER_PARITY_EN
        // 07: bits 1,1,1,0,0,0,0,0 then parity 1
        bus.DATA  = 8'h07;
        bus.VALID = 1'b1;
        @(negedge clk);
        bus.VALID = 1'b0;
        bus.DATA  = 8'h00;
        check_stream("p07", 32'h0000_0107, 32'h0000_0100, 32'hFFFF_FFFF, 0, 9);
        chk_idle("p07_after");
        @(negedge clk);
`endif

        // Reset during bit 3 of FF with 81 held
        bus.DATA  = 8'hFF;
        bus.VALID = 1'b1;
        @(negedge clk);
        bus.DATA  = 8'h81;
        check_stream("rs", 32'h0000_00FF, 32'h0, 32'h0000_0001, 0, 1);
        bus.VALID = 1'b0;
        bus.DATA  = 8'h00;
        check_stream("rs", 32'h0000_00FF, 32'h0, 32'h0000_0000, 1, 3);
        chk("rs_pin3", {31'b0, pin}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_pin_idle", {31'b0, pin},       32'd0);
        chk("rs_busy",     {31'b0, busy},      32'd0);
        chk("rs_done",     {31'b0, done},      32'd0);
        chk("rs_ready_hi", {31'b0, bus.READY}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            chk_idle($sformatf("rs_after%0d", i));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/io_oserializer.md
IO_OSERIALIZER -- requirements
Module: io_oserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits; legal range 2..32.
REQ-002 SHALL have parameter IDLE_Z, default 1: when 1, PIN is released (1'bz) when idle; when 0, PIN is driven 1'b1 when idle.
REQ-003 SHALL have port IOCLK  input  1  single clock; all state updates on posedge IOCLK.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port DATA  input  WIDTH  parallel word to transmit.
REQ-006 SHALL have port VALID  input  1  DATA is valid.
REQ-007 SHALL have port READY  output  1  block can accept a word; transfer occurs on an edge where VALID && READY.
REQ-008 SHALL have port PIN  inout  1  pad, serial output, LSB first.
REQ-009 SHALL have port BUSY  output  1  a word is being shifted onto PIN.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse when a frame completes.

Function
REQ-011 SHALL contain a shift register (WIDTH), a one-word holding register with a full flag, a bit counter of clog2(WIDTH+1) bits, and an FSM with states IDLE, SHIFT and PARITY.
REQ-012 SHALL drive READY = !hold_full, with RST low.
REQ-013 IDLE plus accept: SHALL load DATA into the shift register and enter SHIFT, with PIN = DATA[0] in the cycle after the accepting edge (latency 1).
REQ-014 SHIFT: SHALL drive PIN = shift[0] and shift right once per cycle, for exactly WIDTH cycles per word.
REQ-015 Accept while in SHIFT or PARITY: SHALL write DATA into the holding register and set hold_full.
REQ-016 At frame end (last data bit, or the parity bit if enabled), if hold_full: SHALL move hold into shift, clear hold_full, and stay in SHIFT with no idle gap.
REQ-017 At frame end, if hold is empty and VALID && READY on that same edge: SHALL load DATA directly into shift (bypass) with no gap.
REQ-018 At frame end with no pending word: SHALL return to IDLE.
REQ-019 In IDLE, PIN SHALL be 1'bz if IDLE_Z=1, else 1'b1.
REQ-020 In SHIFT or PARITY, PIN SHALL always be actively driven.
REQ-021 BUSY SHALL be 1 exactly when the state is not IDLE.
REQ-022 DONE SHALL pulse high for the single cycle in which the final bit of each frame is on PIN.
REQ-023 DATA changes while VALID is low SHALL have no effect.

Reset
REQ-024 While RST=1 at posedge IOCLK: state←IDLE, hold_full←0, shift←0, counter←0.
REQ-025 Outputs during and after reset: READY=0 while RST=1; after reset, READY=1, BUSY=0, DONE=0, and PIN at the idle level.
REQ-026 RST asserted mid-frame SHALL discard both the shifting and the held word, with PIN at the idle level from the cycle after the reset edge.

Configuration
REQ-027 Macro IO_OSER_PARITY_EN defined: after the last data bit, the FSM SHALL enter PARITY for one cycle, driving the even parity (XOR of all WIDTH bits) on PIN; a frame is WIDTH+1 cycles.
REQ-028 Macro undefined: PARITY state and parity logic SHALL be absent; a frame is WIDTH cycles.

Structure
REQ-029 Package io_pkg SHALL hold the FSM state enum (io_oser_state_t), the idle-level constants, and the parity helper function, shared with the input-capture IO blocks.
REQ-030 The design SHALL be a single module; the pad tristate is a continuous assignment in io_oserializer; no sub-module.

Verification
REQ-031 Reset then idle, IDLE_Z=1: PIN=z, READY=1, BUSY=0 for 10 cycles.
REQ-032 WIDTH=8, send 8'hA5: PIN sequence 1,0,1,0,0,1,0,1 starting one cycle after accept; DONE pulse on the 8th bit; then idle.
REQ-033 Back-to-back 8'h0F then 8'hF0, the second accepted during the first frame: 16 contiguous bits 1111 0000 0000 1111 with no gap; READY=0 while the holding register is full.
REQ-034 Word accepted on the frame-end edge with hold empty (bypass): the next frame starts the following cycle with no gap.
REQ-035 With IO_OSER_PARITY_EN, send 8'h07: 1,1,1,0,0,0,0,0, then parity bit 1; DONE pulses on the parity cycle.
REQ-036 RST pulsed during bit 3 of 8'hFF with a word held: PIN at the idle level the next cycle, hold dropped, READY=1 after RST falls, and no further DONE.
